// File: rtl/fourstate_pkg.sv
// Shared definitions for the 4-state comparison blocks: compare modes,
// 3-valued result codes and the per-bit {val,unk} encoding.
package fourstate_pkg;

  // Compare modes; the fourth encoding (2'b11) is handled as case equality.
  localparam logic [1:0] MODE_LEQ = 2'b00;  // logical ==
  localparam logic [1:0] MODE_CEQ = 2'b01;  // case ===
  localparam logic [1:0] MODE_WEQ = 2'b10;  // wildcard ==?

  // Result codes; 2'b11 is never produced.
  localparam logic [1:0] RES_FALSE = 2'b00;
  localparam logic [1:0] RES_TRUE  = 2'b01;
  localparam logic [1:0] RES_UNK   = 2'b10;

  // One 4-state bit: 00 -> 0, 10 -> 1, 01 -> x, 11 -> z (as {val,unk}).
  typedef struct packed {
    logic val;
    logic unk;
  } fs_bit_t;

  // A bit carries a definite logic level only when its unknown flag is clear.
  function automatic logic fs_known(fs_bit_t b);
    return !b.unk;
  endfunction

endpackage

// File: rtl/fourstate_eq_core.sv
// Purely combinational W-bit 4-state comparator: expected vs observed
// vectors in ==, === or ==? mode, producing a 3-valued result code.
module fourstate_eq_core
  import fourstate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] e_val,
  input  logic [W-1:0] e_unk,
  input  logic [W-1:0] o_val,
  input  logic [W-1:0] o_unk,
  output logic [1:0]   res_code
);

  // Bits where both sides are known and their levels disagree.
  logic [W-1:0] mis_known;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    fs_bit_t e_b;
    fs_bit_t o_b;
    assign e_b = {e_val[gi], e_unk[gi]};
    assign o_b = {o_val[gi], o_unk[gi]};
    assign mis_known[gi] = fs_known(e_b) && fs_known(o_b) && (e_b.val != o_b.val);
  end

  // Mode decode; wildcard masks out bits the expected side marks unknown.
  always_comb begin
    res_code = RES_FALSE;
    case (mode)
      MODE_LEQ: begin
        if (|mis_known)             res_code = RES_FALSE;
        else if (|(e_unk | o_unk))  res_code = RES_UNK;
        else                        res_code = RES_TRUE;
      end
      MODE_WEQ: begin
        if (|(mis_known & ~e_unk))  res_code = RES_FALSE;
        else if (|(o_unk & ~e_unk)) res_code = RES_UNK;
        else                        res_code = RES_TRUE;
      end
      default: begin
        // Case equality, also used for the reserved mode: x and z are distinct values.
        res_code = ((e_val == o_val) && (e_unk == o_unk)) ? RES_TRUE : RES_FALSE;
      end
    endcase
  end

endmodule

// File: rtl/fourstate_cmp_scoreboard.sv
// Clocked scoreboard: expected 4-state vectors queue in a FIFO, each
// observation pops the head and compares it, the registered result feeds
// saturating pass/fail/unknown counters.
module fourstate_cmp_scoreboard
  import fourstate_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [W-1:0]             exp_val,
  input  logic [W-1:0]             exp_unk,
  input  logic                     obs_valid,
  input  logic [W-1:0]             obs_val,
  input  logic [W-1:0]             obs_unk,
  output logic                     res_valid,
  output logic [1:0]               res_code,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         unk_cnt,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE  = 1;
  localparam logic [AW-1:0]  PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [W-1:0]  val_mem [DEPTH];
  logic [W-1:0]  unk_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;
  logic [1:0]    core_res;
  logic          res_valid_q;
  logic [1:0]    res_code_q;
  logic          underflow_q, underflow_d;
  // Counter slots indexed by result code: 0 false, 1 true, 2 unknown.
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // The same-cycle push is decided on the old level, so an empty FIFO never
  // forwards a push to an observation, and a full FIFO refuses a push even when popping.
  assign exp_ready = (level_q != FULL_LVL);
  assign push      = exp_valid && exp_ready;
  assign pop       = obs_valid && (level_q != '0);

  fourstate_eq_core #(.W(W)) u_core (
    .mode     (mode),
    .e_val    (val_mem[rd_ptr_q]),
    .e_unk    (unk_mem[rd_ptr_q]),
    .o_val    (obs_val),
    .o_unk    (obs_unk),
    .res_code (core_res)
  );

  // FIFO storage writes; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      val_mem[wr_ptr_q] <= exp_val;
      unk_mem[wr_ptr_q] <= exp_unk;
    end
  end

  // Next-state for pointers, occupancy, sticky underflow and the counters.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop) level_d = level_q + LVL_ONE;
    if (pop && !push) level_d = level_q - LVL_ONE;
    underflow_d = underflow_q | (obs_valid && (level_q == '0));
    if (clr) underflow_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr)
        cnt_d[i] = '0;
      else if (res_valid_q && (res_code_q == 2'(i)) && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + CNT_ONE;
    end
  end

  // State registers; reset drops any result still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      res_valid_q <= 1'b0;
      res_code_q  <= RES_FALSE;
      underflow_q <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      res_valid_q <= pop;
      if (pop) res_code_q <= core_res;
      underflow_q <= underflow_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign res_valid = res_valid_q;
  assign res_code  = res_code_q;
  assign fail_cnt  = cnt_q[0];
  assign pass_cnt  = cnt_q[1];
  assign unk_cnt   = cnt_q[2];
  assign underflow = underflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fourstate_cmp_scoreboard.sv
// Self-checking bench for fourstate_cmp_scoreboard: directed vector table,
// hand-written FIFO/counter/reset sequences and a randomized phase, all
// checked against a queue-based reference model.
module tb_fourstate_cmp_scoreboard;
  localparam int W = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] mode;
  logic exp_valid, exp_ready, obs_valid, res_valid, underflow, clr;
  logic [W-1:0] exp_val, exp_unk, obs_val, obs_unk;
  logic [1:0] res_code;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, unk_cnt;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  fourstate_cmp_scoreboard #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_val(exp_val), .exp_unk(exp_unk),
    .obs_valid(obs_valid), .obs_val(obs_val), .obs_unk(obs_unk),
    .res_valid(res_valid), .res_code(res_code),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .unk_cnt(unk_cnt),
    .underflow(underflow), .level(level), .clr(clr)
  );

  typedef struct { logic [W-1:0] v; logic [W-1:0] u; } pair_t;
  typedef struct { int md; pair_t e; pair_t o; int code; } vec_t;

  // Reference model state
  pair_t mq[$];
  bit    m_rv;
  int    m_rc, m_pass, m_fail, m_unk;
  bit    m_uf;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // 4-state value of one bit: 0, 1, 2 = x, 3 = z
  function automatic int st(input logic v, input logic u);
    return u ? (v ? 3 : 2) : (v ? 1 : 0);
  endfunction

  // Comparison rules stated over 4-state bit values
  function automatic int ref_cmp(input int md, input pair_t e, input pair_t o);
    bit f = 0;
    bit x = 0;
    for (int i = 0; i < W; i++) begin
      int es = st(e.v[i], e.u[i]);
      int os = st(o.v[i], o.u[i]);
      if (md == 0) begin
        if (es < 2 && os < 2 && es != os) f = 1;
        if (es >= 2 || os >= 2) x = 1;
      end else if (md == 2) begin
        if (es < 2) begin
          if (os < 2 && es != os) f = 1;
          if (os >= 2) x = 1;
        end
      end else begin
        if (es != os) f = 1;
      end
    end
    return f ? 0 : (x ? 2 : 1);
  endfunction

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rv = 0; m_rc = 0; m_pass = 0; m_fail = 0; m_unk = 0; m_uf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".res_valid"}, res_valid, m_rv);
    if (m_rv) chk({tag, ".res_code"}, res_code, m_rc);
    chk({tag, ".pass_cnt"}, pass_cnt, m_pass);
    chk({tag, ".fail_cnt"}, fail_cnt, m_fail);
    chk({tag, ".unk_cnt"}, unk_cnt, m_unk);
    chk({tag, ".underflow"}, underflow, m_uf);
    chk({tag, ".level"}, level, mq.size());
    chk({tag, ".exp_ready"}, exp_ready, mq.size() < DEPTH);
  endtask

  // One clock cycle: drive, clock, advance model, compare everything
  task automatic cycle(input string tag, input bit pv, input pair_t pe,
                       input bit ov, input pair_t po, input int md, input bit c);
    int  nsz;
    bit  do_pop, do_push;
    int  code;
    @(negedge clk);
    exp_valid = pv; exp_val = pe.v; exp_unk = pe.u;
    obs_valid = ov; obs_val = po.v; obs_unk = po.u;
    mode = 2'(md); clr = c;
    @(posedge clk);
    nsz     = mq.size();
    do_pop  = ov && (nsz > 0);
    do_push = pv && (nsz < DEPTH);
    code    = 0;
    if (do_pop) code = ref_cmp(md, mq[0], po);
    if (c) begin
      m_pass = 0; m_fail = 0; m_unk = 0; m_uf = 0;
    end else begin
      if (m_rv) begin
        if (m_rc == 0) m_fail = sat_inc(m_fail);
        else if (m_rc == 1) m_pass = sat_inc(m_pass);
        else m_unk = sat_inc(m_unk);
      end
      if (ov && nsz == 0) m_uf = 1;
    end
    if (do_pop) begin
      void'(mq.pop_front());
      m_rv = 1; m_rc = code;
    end else begin
      m_rv = 0;
    end
    if (do_push) mq.push_back(pe);
    #1;
    $display("cyc %s push=%0b obs=%0b mode=%0d clr=%0b -> rv=%0b code=%0d lvl=%0d p/f/u=%0d/%0d/%0d uf=%0b",
             tag, pv, ov, md, c, res_valid, res_code, level, pass_cnt, fail_cnt, unk_cnt, underflow);
    check_all(tag);
  endtask

  function automatic pair_t mk(input logic [W-1:0] v, input logic [W-1:0] u);
    pair_t p;
    p.v = v; p.u = u;
    return p;
  endfunction

  vec_t tbl[12];
  pair_t z2, p00;

  initial begin
    z2 = mk(2'b00, 2'b00);
    p00 = mk(2'b00, 2'b00);
    // mode, E {val,unk}, O {val,unk}, expected code (digits written msb..lsb)
    tbl[0]  = '{0, mk(2'b00, 2'b01), mk(2'b00, 2'b00), 2}; // 0x == 00 -> x
    tbl[1]  = '{0, mk(2'b00, 2'b01), mk(2'b10, 2'b00), 0}; // 0x == 10 -> 0
    tbl[2]  = '{0, mk(2'b00, 2'b01), mk(2'b00, 2'b01), 2}; // 0x == 0x -> x
    tbl[3]  = '{1, mk(2'b01, 2'b10), mk(2'b01, 2'b10), 1}; // x1 === x1
    tbl[4]  = '{1, mk(2'b00, 2'b11), mk(2'b01, 2'b11), 0}; // xx === xz
    tbl[5]  = '{1, mk(2'b10, 2'b10), mk(2'b10, 2'b10), 1}; // z0 === z0
    tbl[6]  = '{2, mk(2'b10, 2'b01), mk(2'b10, 2'b00), 1}; // 10 ==? 1x
    tbl[7]  = '{2, mk(2'b10, 2'b01), mk(2'b01, 2'b01), 0}; // 0z ==? 1x
    tbl[8]  = '{2, mk(2'b00, 2'b10), mk(2'b11, 2'b00), 0}; // 11 ==? x0
    tbl[9]  = '{2, mk(2'b10, 2'b01), mk(2'b11, 2'b01), 1}; // 1z ==? 1x
    tbl[10] = '{3, mk(2'b01, 2'b10), mk(2'b01, 2'b10), 1}; // reserved acts as ===
    tbl[11] = '{3, mk(2'b01, 2'b00), mk(2'b00, 2'b01), 0}; // 01 vs 0x: === false, not x

    rst_n = 1'b0;
    exp_valid = 0; exp_val = 0; exp_unk = 0;
    obs_valid = 0; obs_val = 0; obs_unk = 0; mode = 0; clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.res_code", res_code, 0);
    rst_n = 1'b1;

    // Directed vector table: push then observe each entry
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        cycle("tbl_idle", 0, z2, 0, z2, 0, 0);
        chk("leq_seq.pass", pass_cnt, 0);
        chk("leq_seq.fail", fail_cnt, 1);
        chk("leq_seq.unk", unk_cnt, 2);
      end
      cycle($sformatf("tbl%0d_push", i), 1, tbl[i].e, 0, z2, tbl[i].md, 0);
      cycle($sformatf("tbl%0d_obs", i), 0, z2, 1, tbl[i].o, tbl[i].md, 0);
      chk($sformatf("tbl%0d.valid", i), res_valid, 1);
      chk($sformatf("tbl%0d.code", i), res_code, tbl[i].code);
    end
    cycle("idle", 0, z2, 0, z2, 0, 1);

    // FIFO full: 5 pushes, 5th dropped; then 5 observes, 5th underflows
    for (int k = 0; k < 5; k++) begin
      cycle($sformatf("full_push%0d", k), 1, p00, 0, z2, 0, 0);
      if (k == 3) begin
        chk("full.exp_ready", exp_ready, 0);
        chk("full.level", level, 4);
      end
    end
    chk("full.level_after5", level, 4);
    for (int k = 0; k < 5; k++)
      cycle($sformatf("drain%0d", k), 0, z2, 1, p00, 0, 0);
    chk("drain.underflow", underflow, 1);
    chk("drain.level", level, 0);

    // Simultaneous push/pop at empty and at full
    cycle("sim_clr", 0, z2, 0, z2, 0, 1);
    cycle("sim_empty", 1, p00, 1, p00, 0, 0);
    chk("sim_empty.underflow", underflow, 1);
    chk("sim_empty.level", level, 1);
    chk("sim_empty.no_result", res_valid, 0);
    for (int k = 0; k < 3; k++) cycle("sim_fill", 1, p00, 0, z2, 0, 0);
    cycle("sim_full", 1, p00, 1, p00, 0, 0);
    chk("sim_full.level", level, 3);
    for (int k = 0; k < 3; k++) cycle("sim_drain", 0, z2, 1, p00, 0, 0);

    // Saturation at CNT_MAX, then clr beating a same-cycle increment
    cycle("sat_clr", 0, z2, 0, z2, 0, 1);
    cycle("sat_uf", 0, z2, 1, p00, 0, 0);
    cycle("sat_push", 1, p00, 0, z2, 0, 0);
    for (int k = 0; k < 5; k++) cycle("sat_pp", 1, p00, 1, p00, 1, 0);
    cycle("sat_idle", 0, z2, 0, z2, 0, 0);
    chk("sat.pass_cnt", pass_cnt, 3);
    chk("sat.underflow", underflow, 1);
    cycle("sat_pop", 0, z2, 1, p00, 1, 0);
    chk("sat_pop.res_valid", res_valid, 1);
    cycle("sat_clrhit", 0, z2, 0, z2, 0, 1);
    chk("clr.pass_cnt", pass_cnt, 0);
    chk("clr.underflow", underflow, 0);

    // Asynchronous reset while a result is pending
    cycle("rst_push0", 1, p00, 0, z2, 0, 0);
    cycle("rst_push1", 1, p00, 0, z2, 0, 0);
    cycle("rst_pop", 0, z2, 1, p00, 0, 0);
    #1;
    rst_n = 1'b0;
    exp_valid = 0; obs_valid = 0; clr = 0;
    #1;
    model_reset();
    $display("async reset -> rv=%0b lvl=%0d rdy=%0b p/f/u=%0d/%0d/%0d", res_valid, level, exp_ready,
             pass_cnt, fail_cnt, unk_cnt);
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_hold");
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      pair_t re, ro;
      re = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      ro = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      cycle($sformatf("rnd%0d", n), bit'($urandom_range(0, 1)), re,
            bit'($urandom_range(0, 1)), ro, int'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fourstate_cmp_scoreboard.md
Name: fourstate_cmp_scoreboard

Overview:
- Parametrised, clocked successor to our combinational 4-state equality checks.
- Software-visible 4-state vectors are encoded as value/unknown bit pairs: val=0,unk=0 is 0; val=1,unk=0 is 1; val=0,unk=1 is x; val=1,unk=1 is z.
- Expected vectors are queued in a FIFO. Each observation pops one entry and compares it in a selectable mode: logical ==, case ===, or wildcard ==?.
- Outputs are a registered 3-valued result plus saturating pass/fail/unknown counters. Used as a self-checking scoreboard in Verilator regression benches.

Parameters:
W, 8, compared vector width in bits (>=1)
DEPTH, 4, expected-FIFO depth in entries (power of 2, >=2)
CNT_W, 16, width of each saturating statistics counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  00 logical ==, 01 case ===, 10 wildcard ==?, 11 reserved (treated as 01)
exp_valid  in  1  push request for the expected FIFO
exp_ready  out  1  FIFO not full
exp_val  in  W  expected value bits
exp_unk  in  W  expected unknown bits
obs_valid  in  1  observation strobe (no backpressure)
obs_val  in  W  observed value bits
obs_unk  in  W  observed unknown bits
res_valid  out  1  result strobe, one cycle
res_code  out  2  00 false, 01 true, 10 unknown (x); 11 never driven
pass_cnt  out  CNT_W  count of true results
fail_cnt  out  CNT_W  count of false results
unk_cnt  out  CNT_W  count of unknown results
underflow  out  1  sticky: observation arrived with FIFO empty
level  out  clog2(DEPTH)+1  current FIFO occupancy
clr  in  1  synchronous clear of counters and underflow (FIFO untouched)

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; level=0; exp_ready=1.
  - res_valid=0, res_code=00.
  - All counters 0; underflow=0.
  - Effect is immediate and mid-operation safe: any in-flight result is discarded.
- Push: exp_valid&&exp_ready writes {exp_val,exp_unk} at the tail.
  - Push when full is ignored; exp_ready=0 whenever level==DEPTH.
- Observe, obs_valid with level>0:
  - Head entry is popped and compared against obs_* combinationally.
  - Result registered: res_valid=1 with res_code in the next cycle. Latency is 1 cycle.
- Observe with level==0: no pop, no result, res_valid stays 0, underflow set sticky.
- Simultaneous push and pop in one cycle:
  - Both take effect; level unchanged.
  - When level==0, the pushed entry is not visible to the same-cycle observation, which underflows.
  - When full, exp_ready remains 0 that cycle, so no push occurs even though a pop frees a slot.
- Per-bit states: known = !unk. Bit i mismatch-known = both known and val differ.
- Mode semantics (E = expected, O = observed):
  - == : any mismatch-known -> false. Else any unk in E or O -> unknown. Else true.
  - === : true iff E.val==O.val and E.unk==O.unk over all bits (x and z distinguished). Else false. Never unknown.
  - ==? : bits where E.unk=1 are don't-care. Over the remaining bits: any mismatch-known -> false; else any O.unk -> unknown; else true.
- mode is sampled in the pop cycle.
- Counters:
  - Increment in the cycle res_valid is asserted, according to res_code.
  - Each saturates at 2^CNT_W-1 with no wrap.
  - clr zeroes counters and underflow. clr wins over a same-cycle increment.
- level tracks pushes/pops exactly. Read/write pointers wrap modulo DEPTH.

Decomposition:
- Shared package fourstate_pkg:
  - mode constants MODE_LEQ/MODE_CEQ/MODE_WEQ.
  - result constants RES_FALSE/RES_TRUE/RES_UNK.
  - a typedef for the {val,unk} pair.
- One natural sub-module: fourstate_eq_core. It is the purely combinational W-bit comparator, mode -> res_code, reusable outside the scoreboard.
- The FIFO, result register and counters stay in the top.

Test Plan:
- W=2, mode==. Push E=0x (val=00,unk=01) three times, then observe 00, 10, 0x -> res_code 10, 00, 10. pass=0, fail=1, unk=2.
- W=2, mode===. Push x1, xx, z0; observe x1, xz, z0 -> 01, 00, 01. Never 10.
- W=2, mode==?. Push 1x, 1x, x0; observe 10, 0z, 11 -> 01, 00, 00. E 1x vs O 1z -> 01.
- DEPTH=4. Push 5 with no observe -> exp_ready=0 after the 4th, level=4, 5th dropped. Then observe 5 times -> 4 results, 5th sets underflow, level=0.
- CNT_W=2. Issue 5 true compares -> pass_cnt saturates at 3. Assert clr with a result strobing in the same cycle -> pass_cnt=0 and underflow cleared.
- Assert rst_n low the cycle after a pop, while res_valid is due -> res_valid stays 0, level=0, counters 0, exp_ready=1 asynchronously.
